mult_operand_reader: RTL and testbench
======================================

Name: mult_operand_reader

Overview:
- Read-side counterpart of the multiply AFU's single-line write path.
- Fetches a host buffer of NUM cache lines over CCI-P channel 0 (c0Tx read requests, c0Rx read responses).
- Each line holds an operand pair. The block multiplies each pair and streams the 64-bit products out in line order over a valid/ready interface.
- Sits between the MPF channel-0 ports and the AFU's result/write logic; a thin wrapper maps its flat ports onto cci_mpf_if.

Parameters:
- MAX_OUTSTANDING, 8, reorder window depth and maximum reads in flight; power of two, 2..64.
- NUM_LINES_W, 16, width of line count and index; at most 16, the mdata width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle pulse that begins a job; sampled only in IDLE
- base_addr  in  42  t_ccip_clAddr of line 0
- num_lines  in  NUM_LINES_W  lines to read; captured at start
- c0tx_valid  out  1  read request valid; registered
- c0tx_addr  out  42  base_addr + issue index
- c0tx_mdata  out  16  zero-extended issue index
- c0tx_almfull  in  1  channel-0 almost full; no request issued while high
- c0rx_valid  in  1  read response valid (data responses only)
- c0rx_mdata  in  16  tag of response
- c0rx_data  in  512  line data; a = [63:0], b = [127:64]
- prod_valid  out  1  product available
- prod_data  out  64  low 64 bits of a*b
- prod_idx  out  NUM_LINES_W  line index of product
- prod_ready  in  1  consumer accepts the product
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when the last product is accepted
- err  out  1  sticky: a response arrived with a tag outside the window; cleared by start

Behaviour:
- Reset is synchronous and active-high, clock clk. All outputs are 0 on reset: c0tx_valid, prod_valid, busy, done, err, and all counters. All reorder-buffer slot-valid bits are cleared.
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN on start. start captures base_addr and num_lines and clears err, issue_idx, emit_idx.
  - RUN -> FINISH when emit_idx == num_lines.
  - FINISH -> IDLE after one cycle, pulsing done.
  - num_lines == 0: RUN -> FINISH immediately, no reads issued.
  - start outside IDLE is ignored.
- Issue rule, evaluated in RUN: issue when issue_idx < num_lines AND (issue_idx - emit_idx) < MAX_OUTSTANDING AND !c0tx_almfull.
  - Request registers load on the issue cycle and appear on c0tx_* the next cycle.
  - c0tx_valid is a single-cycle pulse per request.
  - Start at cycle T gives RUN at T+1 and the first c0tx_valid at T+2.
- Response rule: responses may return in any order.
  - slot = mdata mod MAX_OUTSTANDING. The slot stores c0rx_data[127:0] and sets its valid bit.
  - Accept only if RUN and emit_idx <= mdata < issue_idx. Otherwise drop the response and set err.
  - Responses arriving in IDLE after a reset or an aborted job are dropped silently, without setting err.
- Emit rule: when slot[emit_idx mod D] is valid and the output register is empty or being accepted:
  - load prod_data = (a*b)[63:0] (unsigned, truncated) and prod_idx = emit_idx;
  - clear the slot valid bit and increment emit_idx.
  - Latency from response to prod_valid is 2 cycles: slot write, then output register.
- Output handshake: prod_valid, prod_data and prod_idx hold stable until prod_valid && prod_ready.
  - Back-to-back products are sustained at one per cycle when prod_ready stays high.
- Window-full behaviour: issue stalls when MAX_OUTSTANDING lines are unemitted. Consumer back-pressure therefore throttles reads with no data loss.
- Simultaneous events:
  - A slot write and a slot emit in the same cycle target different slots by construction.
  - A response landing in the head slot is emittable the following cycle.
- Index arithmetic wraps modulo 2^NUM_LINES_W. Address adds are 42-bit, with no overflow detection.
- Reset mid-job returns to IDLE immediately. done is not pulsed.

Optional Feature:
- Macro: MULT_OPERAND_READER_CHECKSUM_EN.
- When defined:
  - adds output checksum[63:0], the wrap-around sum of every accepted prod_data in the current job;
  - checksum is cleared at start and on reset, and is valid when done pulses.
- When undefined: the port and its adder are absent; behaviour is otherwise identical.

Decomposition:
- Package mult_reader_pkg: line field offsets (OPA_LSB=0, OPB_LSB=64, OP_W=64), t_line_idx typedef, t_operand_pair struct {a, b}.
- Sub-module mult_reader_rob: the reorder buffer, holding slot storage, valid bits, write port and head-read port, parameterised by MAX_OUTSTANDING. The top level holds the FSM, issue logic, multiplier and output register.

Test Plan:
- num_lines=1, line a=3, b=5, base_addr=0x1000 -> one c0tx at addr 0x1000, mdata 0; prod_data=15, prod_idx=0; done pulses once.
- num_lines=4, responses returned in order 3,1,0,2 with a=i+1, b=10 -> products 10,20,30,40 emitted in idx order 0..3.
- num_lines=20, MAX_OUTSTANDING=8, prod_ready held low -> exactly 8 requests issued, then stall; releasing prod_ready completes all 20 with no gaps or duplicates.
- c0tx_almfull high for 5 cycles mid-job -> no c0tx_valid during those cycles; issue resumes the cycle after deassertion.
- num_lines=0 -> no c0tx_valid; done pulses at T+2. A response with mdata=9 while window=[0,8) -> dropped, err=1.
- With MULT_OPERAND_READER_CHECKSUM_EN: a=0xFFFF_FFFF_FFFF_FFFF, b=2 for 2 lines -> each prod_data=0xFFFF_FFFF_FFFF_FFFE; checksum=0xFFFF_FFFF_FFFF_FFFC.

Source files
------------

// File: rtl/mult_reader_pkg.sv
// Shared types and cache-line field layout for the multiply operand reader.
package mult_reader_pkg;

    localparam int unsigned CL_ADDR_W  = 42;
    localparam int unsigned CL_DATA_W  = 512;
    localparam int unsigned MDATA_W    = 16;
    localparam int unsigned LINE_IDX_W = 16;
    localparam int unsigned OPA_LSB    = 0;
    localparam int unsigned OPB_LSB    = 64;
    localparam int unsigned OP_W       = 64;
    localparam int unsigned PAIR_W     = 2 * OP_W;

    typedef logic [LINE_IDX_W-1:0] t_line_idx;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } t_operand_pair;

    // Pull the operand pair out of a raw cache line.
    function automatic t_operand_pair unpack_line(input logic [CL_DATA_W-1:0] line);
        t_operand_pair pair;
        pair.a = line[OPA_LSB +: OP_W];
        pair.b = line[OPB_LSB +: OP_W];
        return pair;
    endfunction

endpackage

// File: rtl/mult_reader_rob.sv
// Reorder buffer: one operand-pair slot per outstanding read, written by tag,
// drained in line order through the head port.
module mult_reader_rob
    import mult_reader_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned SLOT_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [SLOT_W-1:0]   wr_slot,
    input  t_operand_pair       wr_pair,
    input  logic [SLOT_W-1:0]   head_slot,
    input  logic                head_pop,
    output logic                head_valid_c,
    output t_operand_pair       head_pair_c
);

    logic [DEPTH-1:0] slot_valid;
    t_operand_pair    slot_mem [DEPTH];

    // Write and pop never hit the same slot within one cycle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            slot_valid <= '0;
        end else begin
            if (head_pop) begin
                slot_valid[head_slot] <= 1'b0;
            end
            if (wr_en) begin
                slot_valid[wr_slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            slot_mem[wr_slot] <= wr_pair;
        end
    end

    assign head_valid_c = slot_valid[head_slot];
    assign head_pair_c  = slot_mem[head_slot];

endmodule

// File: rtl/mult_operand_reader.sv
// Reads NUM operand-pair lines over CCI-P channel 0 and streams a*b in line order.
// Optional running checksum output: define MULT_OPERAND_READER_CHECKSUM_EN.
module mult_operand_reader
    import mult_reader_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned NUM_LINES_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CL_ADDR_W-1:0]   base_addr,
    input  logic [NUM_LINES_W-1:0] num_lines,
    output logic                   c0tx_valid,
    output logic [CL_ADDR_W-1:0]   c0tx_addr,
    output logic [MDATA_W-1:0]     c0tx_mdata,
    input  logic                   c0tx_almfull,
    input  logic                   c0rx_valid,
    input  logic [MDATA_W-1:0]     c0rx_mdata,
    input  logic [CL_DATA_W-1:0]   c0rx_data,
    output logic                   prod_valid,
    output logic [OP_W-1:0]        prod_data,
    output logic [NUM_LINES_W-1:0] prod_idx,
    input  logic                   prod_ready,
    output logic                   busy,
    output logic                   done,
`ifdef MULT_OPERAND_READER_CHECKSUM_EN
    output logic [OP_W-1:0]        checksum,
`endif
    output logic                   err
);

    localparam int unsigned SLOT_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W  = NUM_LINES_W + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [CL_ADDR_W-1:0]   base_addr_q;
    logic [NUM_LINES_W-1:0] num_lines_q;
    logic [NUM_LINES_W-1:0] issue_idx;
    logic [NUM_LINES_W-1:0] emit_idx;

    logic [NUM_LINES_W-1:0] in_flight;
    logic [NUM_LINES_W-1:0] rsp_off;
    logic                   rsp_hi_zero;
    logic                   rsp_in_win;
    logic                   rsp_accept;
    logic                   rsp_bad;
    logic                   job_start;
    logic                   issue_fire;
    logic                   out_free;
    logic                   emit_fire;
    logic                   head_valid;
    t_operand_pair          head_pair;
    logic [OP_W-1:0]        prod_c;
    logic                   unused_line_bits;

    assign job_start   = (state_q == IDLE) && start;
    assign in_flight   = issue_idx - emit_idx;
    assign issue_fire  = (state_q == RUN) && (issue_idx < num_lines_q)
                         && ({1'b0, in_flight} < CNT_W'(MAX_OUTSTANDING))
                         && !c0tx_almfull;

    // A tag is live when its offset from the head lies inside the issued window.
    assign rsp_off     = c0rx_mdata[NUM_LINES_W-1:0] - emit_idx;
    assign rsp_hi_zero = (c0rx_mdata >> NUM_LINES_W) == '0;
    assign rsp_in_win  = rsp_hi_zero && (rsp_off < in_flight);
    assign rsp_accept  = c0rx_valid && (state_q == RUN) && rsp_in_win;
    assign rsp_bad     = c0rx_valid && (state_q != IDLE) && !rsp_in_win;

    assign out_free    = !prod_valid || prod_ready;
    assign emit_fire   = (state_q == RUN) && head_valid && out_free;
    assign prod_c      = head_pair.a * head_pair.b;

    assign unused_line_bits = ^c0rx_data[CL_DATA_W-1:PAIR_W];

    mult_reader_rob #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rob (
        .clk          (clk),
        .reset        (reset),
        .clr          (job_start),
        .wr_en        (rsp_accept),
        .wr_slot      (c0rx_mdata[SLOT_W-1:0]),
        .wr_pair      (unpack_line(c0rx_data)),
        .head_slot    (emit_idx[SLOT_W-1:0]),
        .head_pop     (emit_fire),
        .head_valid_c (head_valid),
        .head_pair_c  (head_pair)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job ends once every product has left the output register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if ((emit_idx == num_lines_q) && out_free) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            base_addr_q <= '0;
            num_lines_q <= '0;
            issue_idx   <= '0;
            emit_idx    <= '0;
            c0tx_valid  <= 1'b0;
            c0tx_addr   <= '0;
            c0tx_mdata  <= '0;
            prod_valid  <= 1'b0;
            prod_data   <= '0;
            prod_idx    <= '0;
        end else begin
            busy       <= (state_d != IDLE);
            done       <= (state_d == FINISH);
            c0tx_valid <= issue_fire;

            if (job_start) begin
                base_addr_q <= base_addr;
                num_lines_q <= num_lines;
                issue_idx   <= '0;
                emit_idx    <= '0;
                err         <= 1'b0;
            end else begin
                if (rsp_bad) begin
                    err <= 1'b1;
                end
                if (issue_fire) begin
                    c0tx_addr  <= base_addr_q + CL_ADDR_W'(issue_idx);
                    c0tx_mdata <= MDATA_W'(t_line_idx'(issue_idx));
                    issue_idx  <= issue_idx + NUM_LINES_W'(1);
                end
                if (emit_fire) begin
                    emit_idx <= emit_idx + NUM_LINES_W'(1);
                end
            end

            if (emit_fire) begin
                prod_valid <= 1'b1;
                prod_data  <= prod_c;
                prod_idx   <= emit_idx;
            end else if (prod_ready) begin
                prod_valid <= 1'b0;
            end
        end
    end

`ifdef MULT_OPERAND_READER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || job_start) begin
            checksum <= '0;
        end else if (prod_valid && prod_ready) begin
            checksum <= checksum + prod_data;
        end
    end
`endif

endmodule

// File: tb/tb_mult_operand_reader.sv
// Directed self-checking bench for mult_operand_reader with a tag-driven response model.
module tb_mult_operand_reader;

    logic         clk;
    logic         reset;
    logic         start;
    logic [41:0]  base_addr;
    logic [15:0]  num_lines;
    logic         c0tx_valid;
    logic [41:0]  c0tx_addr;
    logic [15:0]  c0tx_mdata;
    logic         c0tx_almfull;
    logic         c0rx_valid;
    logic [15:0]  c0rx_mdata;
    logic [511:0] c0rx_data;
    logic         prod_valid;
    logic [63:0]  prod_data;
    logic [15:0]  prod_idx;
    logic         prod_ready;
    logic         busy;
    logic         done;
    logic         err;
`ifdef MULT_OPERAND_READER_CHECKSUM_EN
    logic [63:0]  checksum;
`endif

    mult_operand_reader #(
        .MAX_OUTSTANDING (8),
        .NUM_LINES_W     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_lines    (num_lines),
        .c0tx_valid   (c0tx_valid),
        .c0tx_addr    (c0tx_addr),
        .c0tx_mdata   (c0tx_mdata),
        .c0tx_almfull (c0tx_almfull),
        .c0rx_valid   (c0rx_valid),
        .c0rx_mdata   (c0rx_mdata),
        .c0rx_data    (c0rx_data),
        .prod_valid   (prod_valid),
        .prod_data    (prod_data),
        .prod_idx     (prod_idx),
        .prod_ready   (prod_ready),
        .busy         (busy),
        .done         (done),
`ifdef MULT_OPERAND_READER_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [63:0] op_a [32];
    logic [63:0] op_b [32];
    logic [41:0] cur_base;
    logic [15:0] req_q [$];
    logic [15:0] pidx_q [$];
    logic [63:0] pdata_q [$];
    int req_cnt  = 0;
    int addr_bad = 0;
    int done_cnt = 0;
    int alm_viol = 0;
    logic resume_seen;

    // Observe the request and product channels as the DUT sees them at each edge.
    always @(posedge clk) begin
        if (!reset && c0tx_valid) begin
            req_q.push_back(c0tx_mdata);
            req_cnt++;
            if (c0tx_addr !== cur_base + 42'(c0tx_mdata)) addr_bad++;
        end
        if (!reset && prod_valid && prod_ready) begin
            pidx_q.push_back(prod_idx);
            pdata_q.push_back(prod_data);
        end
        if (!reset && done) done_cnt++;
    end

    task automatic drive_resp(input int idx);
        c0rx_valid         = 1'b1;
        c0rx_mdata         = 16'(idx);
        c0rx_data          = '0;
        c0rx_data[63:0]    = op_a[idx % 32];
        c0rx_data[127:64]  = op_b[idx % 32];
    endtask

    task automatic send_resp(input int idx);
        drive_resp(idx);
        @(negedge clk);
        c0rx_valid = 1'b0;
    endtask

    task automatic start_job(input logic [41:0] base, input int n);
        req_q.delete();
        pidx_q.delete();
        pdata_q.delete();
        req_cnt   = 0;
        addr_bad  = 0;
        done_cnt  = 0;
        cur_base  = base;
        base_addr = base;
        num_lines = 16'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Answer one queued request per cycle until done; optionally hold almfull for a window.
    task automatic serve(input string tag, input int budget, input int alm_from, input int alm_len);
        bit finished = 1'b0;
        bit prev_alm = 1'b0;
        alm_viol    = 0;
        resume_seen = 1'b0;
        for (int k = 0; k < budget && !finished; k++) begin
            if (prev_alm && c0tx_valid) alm_viol++;
            if (alm_len > 0 && k == alm_from + alm_len + 1) resume_seen = c0tx_valid;
            if (done) begin
                finished = 1'b1;
            end else begin
                c0tx_almfull = (k >= alm_from) && (k < alm_from + alm_len);
                prev_alm     = c0tx_almfull;
                if (req_q.size() > 0) drive_resp(int'(req_q.pop_front()));
                else c0rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        c0rx_valid   = 1'b0;
        c0tx_almfull = 1'b0;
        check({tag, "_done_seen"}, 64'(finished), 64'd1);
    endtask

    task automatic verify_products(input string tag, input int n);
        check({tag, "_nprod"}, 64'(pidx_q.size()), 64'(n));
        for (int i = 0; i < n && i < pidx_q.size(); i++) begin
            check($sformatf("%s_idx%0d", tag, i), 64'(pidx_q[i]), 64'(i));
            check($sformatf("%s_data%0d", tag, i), pdata_q[i], op_a[i] * op_b[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp2 [4];
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_lines    = '0;
        c0tx_almfull = 1'b0;
        c0rx_valid   = 1'b0;
        c0rx_mdata   = '0;
        c0rx_data    = '0;
        prod_ready   = 1'b0;
        cur_base     = '0;
        resume_seen  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_c0tx_valid", 64'(c0tx_valid), 64'd0);
        check("rst_prod_valid", 64'(prod_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single line: exact cycle timing of request, product and done.
        op_a[0] = 64'd3;
        op_b[0] = 64'd5;
        prod_ready = 1'b1;
        start_job(42'h1000, 1);
        check("t1_no_req_yet", 64'(c0tx_valid), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_req_valid", 64'(c0tx_valid), 64'd1);
        check("t1_req_addr", 64'(c0tx_addr), 64'h1000);
        check("t1_req_mdata", 64'(c0tx_mdata), 64'd0);
        @(negedge clk);
        check("t1_req_pulse", 64'(c0tx_valid), 64'd0);
        send_resp(0);
        check("t1_lat_slot", 64'(prod_valid), 64'd0);
        @(negedge clk);
        check("t1_prod_valid", 64'(prod_valid), 64'd1);
        check("t1_prod_data", prod_data, 64'd15);
        check("t1_prod_idx", 64'(prod_idx), 64'd0);
        @(negedge clk);
        check("t1_done", 64'(done), 64'd1);
        @(negedge clk);
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_err", 64'(err), 64'd0);

        // Four lines answered out of order.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 64'(i + 1);
            op_b[i] = 64'd10;
        end
        exp2 = '{64'd10, 64'd20, 64'd30, 64'd40};
        start_job(42'h2000, 4);
        repeat (6) @(negedge clk);
        check("t2_req_cnt", 64'(req_cnt), 64'd4);
        check("t2_addr", 64'(addr_bad), 64'd0);
        req_q.delete();
        send_resp(3);
        send_resp(1);
        send_resp(0);
        send_resp(2);
        serve("t2", 50, 0, 0);
        check("t2_nprod", 64'(pidx_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < pidx_q.size(); i++) begin
            check($sformatf("t2_idx%0d", i), 64'(pidx_q[i]), 64'(i));
            check($sformatf("t2_data%0d", i), pdata_q[i], exp2[i]);
        end
        check("t2_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);

        // Window fills with consumer stalled, then drains completely.
        for (int i = 0; i < 32; i++) begin
            op_a[i] = 64'(i * 3 + 1);
            op_b[i] = 64'(i + 2);
        end
        prod_ready = 1'b0;
        start_job(42'h4000, 20);
        repeat (20) @(negedge clk);
        check("t3_window_full", 64'(req_cnt), 64'd8);
        check("t3_no_prod", 64'(prod_valid), 64'd0);
        prod_ready = 1'b1;
        serve("t3", 300, 0, 0);
        check("t3_req_cnt", 64'(req_cnt), 64'd20);
        check("t3_addr", 64'(addr_bad), 64'd0);
        verify_products("t3", 20);
        repeat (2) @(negedge clk);

        // almfull held for 5 cycles early in the job.
        start_job(42'h8000, 12);
        serve("t4", 300, 2, 5);
        check("t4_alm_quiet", 64'(alm_viol), 64'd0);
        check("t4_alm_resume", 64'(resume_seen), 64'd1);
        check("t4_req_cnt", 64'(req_cnt), 64'd12);
        verify_products("t4", 12);
        repeat (2) @(negedge clk);

        // Empty job.
        start_job(42'h0, 0);
        check("t5_done_early", 64'(done), 64'd0);
        @(negedge clk);
        check("t5_done_t2", 64'(done), 64'd1);
        @(negedge clk);
        check("t5_no_req", 64'(req_cnt), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);

        // Out-of-window tag sets sticky err; job still completes.
        prod_ready = 1'b0;
        start_job(42'hA000, 20);
        repeat (12) @(negedge clk);
        check("t6_req_cnt", 64'(req_cnt), 64'd8);
        check("t6_err_clear", 64'(err), 64'd0);
        send_resp(9);
        check("t6_err_set", 64'(err), 64'd1);
        prod_ready = 1'b1;
        serve("t6", 300, 0, 0);
        check("t6_err_sticky", 64'(err), 64'd1);
        verify_products("t6", 20);
        repeat (2) @(negedge clk);
        start_job(42'h0, 0);
        check("t6_err_cleared_by_start", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        send_resp(5);
        check("t6_idle_drop_silent", 64'(err), 64'd0);

        // Reset mid-job: back to idle, no done.
        prod_ready = 1'b0;
        start_job(42'hC000, 4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_c0tx", 64'(c0tx_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t7_no_done", 64'(done_cnt), 64'd0);
        prod_ready = 1'b1;

`ifdef MULT_OPERAND_READER_CHECKSUM_EN
        op_a[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b[0] = 64'd2;
        op_a[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b[1] = 64'd2;
        start_job(42'h3000, 2);
        serve("t8", 100, 0, 0);
        check("t8_checksum", checksum, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t8_nprod", 64'(pdata_q.size()), 64'd2);
        for (int i = 0; i < 2 && i < pdata_q.size(); i++) begin
            check($sformatf("t8_data%0d", i), pdata_q[i], 64'hFFFF_FFFF_FFFF_FFFE);
        end
        repeat (2) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
